// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Ports: clk_i/rst_i/clear_i, fetch lookup (lookup_pc_i -> pred_*_o),
//        execute update (upd_*_i -> mispred_o, redirect_pc_o), stats.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int PC_W    = 32,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic [PC_W-1:0]   lookup_pc_i,
  output logic              pred_hit_o,
  output logic              pred_taken_o,
  output logic [PC_W-1:0]   pred_next_pc_o,
  input  logic              upd_valid_i,
  input  logic [PC_W-1:0]   upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [PC_W-1:0]   upd_target_i,
  input  logic              upd_pred_taken_i,
  input  logic [PC_W-1:0]   upd_pred_target_i,
  output logic              mispred_o,
  output logic [PC_W-1:0]   redirect_pc_o,
  output logic [STAT_W-1:0] cnt_branch_o,
  output logic [STAT_W-1:0] cnt_mispred_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int unsigned WT_I = 1 << (CNT_W - 1);
  localparam logic [CNT_W-1:0] WT   = CNT_W'(WT_I);
  localparam logic [CNT_W-1:0] WNT  = CNT_W'(WT_I - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic              r_valid [ENTRIES];
  logic [TAG_W-1:0]  r_tag   [ENTRIES];
  logic [PC_W-1:0]   r_tgt   [ENTRIES];
  logic [CNT_W-1:0]  r_ctr   [ENTRIES];
  logic [STAT_W-1:0] r_cnt_branch;
  logic [STAT_W-1:0] r_cnt_mispred;

  logic [IDX_W-1:0]  w_lidx;
  logic [TAG_W-1:0]  w_ltag;
  logic [IDX_W-1:0]  w_uidx;
  logic [TAG_W-1:0]  w_utag;
  logic              w_uhit;
  logic [CNT_W-1:0]  w_ctr_nxt;
  logic [PC_W-1:0]   w_upc4;
  logic              w_unused;

  assign w_lidx = lookup_pc_i[IDX_W+1:2];
  assign w_ltag = lookup_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign w_uidx = upd_pc_i[IDX_W+1:2];
  assign w_utag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

  // Direction prediction is carried in the target compare,
  // so the predicted-taken bit itself is informational only.
  assign w_unused = ^{lookup_pc_i, upd_pc_i, upd_pred_taken_i};

  always_comb begin
    pred_hit_o     = r_valid[w_lidx] && (r_tag[w_lidx] == w_ltag);
    pred_taken_o   = pred_hit_o && r_ctr[w_lidx][CNT_W-1];
    pred_next_pc_o = lookup_pc_i + PC_W'(4);
    if (pred_taken_o)
      pred_next_pc_o = r_tgt[w_lidx];
  end

  always_comb begin
    w_upc4        = upd_pc_i + PC_W'(4);
    redirect_pc_o = w_upc4;
    mispred_o     = 1'b0;
    if (upd_valid_i && upd_taken_i)
      redirect_pc_o = upd_target_i;
    if (upd_valid_i)
      mispred_o = (redirect_pc_o != upd_pred_target_i);
  end

  always_comb begin
    w_uhit    = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
    w_ctr_nxt = r_ctr[w_uidx];
    if (upd_taken_i) begin
      if (r_ctr[w_uidx] != CMAX)
        w_ctr_nxt = r_ctr[w_uidx] + CNT_W'(1);
    end else begin
      if (r_ctr[w_uidx] != '0)
        w_ctr_nxt = r_ctr[w_uidx] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_tgt[i]   <= '0;
        r_ctr[i]   <= WNT;
      end
      r_cnt_branch  <= '0;
      r_cnt_mispred <= '0;
    end else begin
      if (clear_i) begin
        for (int i = 0; i < ENTRIES; i++) begin
          r_valid[i] <= 1'b0;
          r_tag[i]   <= '0;
          r_tgt[i]   <= '0;
          r_ctr[i]   <= WNT;
        end
      end else if (upd_valid_i) begin
        if (w_uhit) begin
          r_ctr[w_uidx] <= w_ctr_nxt;
          if (upd_taken_i)
            r_tgt[w_uidx] <= upd_target_i;
        end else if (upd_taken_i) begin
          // Allocation evicts whatever aliased here.
          r_valid[w_uidx] <= 1'b1;
          r_tag[w_uidx]   <= w_utag;
          r_tgt[w_uidx]   <= upd_target_i;
          r_ctr[w_uidx]   <= WT;
        end
      end
      if (upd_valid_i && (r_cnt_branch != '1))
        r_cnt_branch <= r_cnt_branch + STAT_W'(1);
      if (mispred_o && (r_cnt_mispred != '1))
        r_cnt_mispred <= r_cnt_mispred + STAT_W'(1);
    end
  end

  assign cnt_branch_o  = r_cnt_branch;
  assign cnt_mispred_o = r_cnt_mispred;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor.
// Stats are built 4 bits wide so saturation is reachable.
module tb_branch_predictor;

  localparam int PC_W   = 32;
  localparam int STAT_W = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              clear_i;
  logic [PC_W-1:0]   lookup_pc_i;
  logic              pred_hit_o;
  logic              pred_taken_o;
  logic [PC_W-1:0]   pred_next_pc_o;
  logic              upd_valid_i;
  logic [PC_W-1:0]   upd_pc_i;
  logic              upd_taken_i;
  logic [PC_W-1:0]   upd_target_i;
  logic              upd_pred_taken_i;
  logic [PC_W-1:0]   upd_pred_target_i;
  logic              mispred_o;
  logic [PC_W-1:0]   redirect_pc_o;
  logic [STAT_W-1:0] cnt_branch_o;
  logic [STAT_W-1:0] cnt_mispred_o;

  int checks = 0;
  int errors = 0;

  branch_predictor #(
    .ENTRIES(16),
    .TAG_W(8),
    .PC_W(PC_W),
    .CNT_W(2),
    .STAT_W(STAT_W)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clear_i(clear_i),
    .lookup_pc_i(lookup_pc_i),
    .pred_hit_o(pred_hit_o),
    .pred_taken_o(pred_taken_o),
    .pred_next_pc_o(pred_next_pc_o),
    .upd_valid_i(upd_valid_i),
    .upd_pc_i(upd_pc_i),
    .upd_taken_i(upd_taken_i),
    .upd_target_i(upd_target_i),
    .upd_pred_taken_i(upd_pred_taken_i),
    .upd_pred_target_i(upd_pred_target_i),
    .mispred_o(mispred_o),
    .redirect_pc_o(redirect_pc_o),
    .cnt_branch_o(cnt_branch_o),
    .cnt_mispred_o(cnt_mispred_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc,
                     input logic tk,
                     input logic [31:0] tgt,
                     input logic [31:0] ptgt);
    upd_valid_i       = 1'b1;
    upd_pc_i          = pc;
    upd_taken_i       = tk;
    upd_target_i      = tgt;
    upd_pred_target_i = ptgt;
    upd_pred_taken_i  = (ptgt != pc + 4);
    #1;
  endtask

  task automatic idle();
    upd_valid_i = 1'b0;
    clear_i     = 1'b0;
    rst_i       = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    lookup_pc_i = pc;
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    clear_i = 1'b0;
    lookup_pc_i = 32'h100;
    upd_valid_i = 1'b0;
    upd_pc_i = '0;
    upd_taken_i = 1'b0;
    upd_target_i = '0;
    upd_pred_taken_i = 1'b0;
    upd_pred_target_i = '0;
    tick();
    idle();

    look(32'h100);
    chk("rst_hit", 32'(pred_hit_o), 32'd0);
    chk("rst_tk", 32'(pred_taken_o), 32'd0);
    chk("rst_npc", pred_next_pc_o, 32'h104);
    chk("rst_cb", 32'(cnt_branch_o), 32'd0);
    chk("rst_cm", 32'(cnt_mispred_o), 32'd0);
    look(32'hFFFF_FFFC);
    chk("wrap_npc", pred_next_pc_o, 32'h0);

    upd_pc_i = 32'h100;
    upd_pred_target_i = 32'h999;
    #1;
    chk("idle_mp", 32'(mispred_o), 32'd0);
    chk("idle_rd", redirect_pc_o, 32'h104);

    upd(32'h100, 1'b1, 32'h200, 32'h104);
    chk("alloc_mp", 32'(mispred_o), 32'd1);
    chk("alloc_rd", redirect_pc_o, 32'h200);
    tick();
    idle();
    look(32'h100);
    chk("a_hit", 32'(pred_hit_o), 32'd1);
    chk("a_tk", 32'(pred_taken_o), 32'd1);
    chk("a_npc", pred_next_pc_o, 32'h200);
    chk("a_cb", 32'(cnt_branch_o), 32'd1);
    chk("a_cm", 32'(cnt_mispred_o), 32'd1);

    for (int i = 0; i < 2; i++) begin
      upd(32'h100, 1'b1, 32'h200, 32'h200);
      chk("t_mp", 32'(mispred_o), 32'd0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      upd(32'h100, 1'b0, 32'h200, 32'h200);
      chk("nt_mp", 32'(mispred_o), 32'd1);
      chk("nt_rd", redirect_pc_o, 32'h104);
      tick();
    end
    idle();
    look(32'h100);
    chk("h_hit", 32'(pred_hit_o), 32'd1);
    chk("h_tk", 32'(pred_taken_o), 32'd0);
    chk("h_npc", pred_next_pc_o, 32'h104);
    chk("h_cb", 32'(cnt_branch_o), 32'd5);
    chk("h_cm", 32'(cnt_mispred_o), 32'd3);

    upd(32'h140, 1'b1, 32'h300, 32'h144);
    chk("al_mp", 32'(mispred_o), 32'd1);
    tick();
    idle();
    look(32'h100);
    chk("al_old", 32'(pred_hit_o), 32'd0);
    look(32'h140);
    chk("al_hit", 32'(pred_hit_o), 32'd1);
    chk("al_npc", pred_next_pc_o, 32'h300);

    look(32'h180);
    upd(32'h180, 1'b1, 32'h400, 32'h184);
    chk("same_hit", 32'(pred_hit_o), 32'd0);
    chk("same_npc", pred_next_pc_o, 32'h184);
    tick();
    idle();
    look(32'h180);
    chk("nxt_hit", 32'(pred_hit_o), 32'd1);
    chk("nxt_npc", pred_next_pc_o, 32'h400);
    chk("nxt_cb", 32'(cnt_branch_o), 32'd7);
    chk("nxt_cm", 32'(cnt_mispred_o), 32'd5);

    clear_i = 1'b1;
    upd(32'h100, 1'b1, 32'h500, 32'h104);
    tick();
    idle();
    look(32'h100);
    chk("clr_100", 32'(pred_hit_o), 32'd0);
    look(32'h180);
    chk("clr_180", 32'(pred_hit_o), 32'd0);
    chk("clr_cb", 32'(cnt_branch_o), 32'd8);
    chk("clr_cm", 32'(cnt_mispred_o), 32'd6);

    for (int i = 0; i < 5; i++) begin
      upd(32'h100 + 32'(i * 4), 1'b1, 32'h600, 32'h0);
      tick();
    end
    chk("pre_cb", 32'(cnt_branch_o), 32'd13);
    rst_i = 1'b1;
    upd(32'h108, 1'b1, 32'h700, 32'h0);
    tick();
    idle();
    look(32'h100);
    chk("mr_hit0", 32'(pred_hit_o), 32'd0);
    look(32'h108);
    chk("mr_hit2", 32'(pred_hit_o), 32'd0);
    chk("mr_cb", 32'(cnt_branch_o), 32'd0);
    chk("mr_cm", 32'(cnt_mispred_o), 32'd0);

    for (int i = 0; i < 15; i++) begin
      upd(32'h100, 1'b1, 32'h200, 32'h0);
      tick();
    end
    chk("full_cb", 32'(cnt_branch_o), 32'd15);
    upd(32'h100, 1'b1, 32'h200, 32'h0);
    tick();
    idle();
    chk("sat_cb", 32'(cnt_branch_o), 32'd15);
    chk("sat_cm", 32'(cnt_mispred_o), 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
